// File: rtl/pipelined_config_tree_adder.sv
// Registered adder tree summing INPUTS_AMOUNT signed operands (full width or two packed half lanes), accumulated per group; `TREE_ADDER_SATURATE_EN` saturates the accumulator.
// Latency: a last beat accepted at edge t raises out_valid_o at edge t+log2(INPUTS_AMOUNT)+1.
// Backpressure: in_ready_o drops while a result is held; the whole pipeline freezes with it.
module pipelined_config_tree_adder #(
    parameter int INPUTS_AMOUNT = 8,
    parameter int P             = 16,
    parameter int OUT_WIDTH     = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic signed [P-1:0]         in_data_i [INPUTS_AMOUNT],
    input  logic                        in_halved_i,
    input  logic [15:0]                 in_acc_len_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic signed [OUT_WIDTH-1:0] out_data_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i
);
    localparam int N    = INPUTS_AMOUNT;
    localparam int L    = $clog2(N);
    localparam int HP   = P / 2;
    localparam int FW   = P + L + 1;
    localparam int HW   = HP + L + 1;
    localparam int ROOT = 2 * N - 2;

    if (N < 2 || (N & (N - 1)) != 0) begin : g_chk_n
        $fatal(1, "INPUTS_AMOUNT must be a power of 2 and at least 2");
    end
    if (P < 4 || (P % 2) != 0) begin : g_chk_p
        $fatal(1, "P must be even and at least 4");
    end
    if (OUT_WIDTH < P + L + 1) begin : g_chk_ow
        $fatal(1, "OUT_WIDTH too narrow for the tree sum");
    end

    // Tree nodes are stored flat: layer s occupies indices [2N - (2N >> s), +(N >> s)).
    function automatic int layer_base(input int s);
        return 2 * N - ((2 * N) >> s);
    endfunction

    logic signed [FW-1:0]        full_q [2*N-1];
    logic signed [HW-1:0]        hi_q   [2*N-1];
    logic signed [HW-1:0]        lo_q   [2*N-1];
    logic [L:0]                  vld_q;
    logic [L:0]                  halved_q;
    logic [L:0]                  last_q;
    logic [15:0]                 cnt_q;
    logic [15:0]                 cnt_d;
    logic [15:0]                 grp_len;
    logic                        beat_last;
    logic                        accept;
    logic                        stall;
    logic signed [FW-1:0]        beat_sum;
    logic signed [OUT_WIDTH-1:0] beat_ext;
    logic signed [OUT_WIDTH-1:0] acc_sum;
    logic signed [OUT_WIDTH-1:0] acc_q;
    logic signed [OUT_WIDTH-1:0] out_data_q;
    logic                        out_valid_q;
`ifdef TREE_ADDER_SATURATE_EN
    logic signed [OUT_WIDTH:0]   wide_sum;
`endif

    assign stall       = out_valid_q && !out_ready_i;
    assign in_ready_o  = !stall;
    assign accept      = in_valid_i && !stall;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;

    // cnt_q holds the beats still owed to the open group; zero means the next beat opens one.
    always_comb begin
        grp_len   = (in_acc_len_i == 16'd0) ? 16'd1 : in_acc_len_i;
        beat_last = (cnt_q == 16'd0) ? (grp_len == 16'd1) : (cnt_q == 16'd1);
        cnt_d     = cnt_q;
        if (accept) begin
            cnt_d = (cnt_q == 16'd0) ? grp_len - 16'd1 : cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!stall) begin
            for (int i = 0; i < N; i++) begin
                full_q[i] <= FW'(in_data_i[i]);
                hi_q[i]   <= HW'($signed(in_data_i[i][P-1:HP]));
                lo_q[i]   <= HW'($signed(in_data_i[i][HP-1:0]));
            end
            for (int s = 1; s <= L; s++) begin
                for (int i = 0; i < (N >> s); i++) begin
                    full_q[layer_base(s)+i] <= full_q[layer_base(s-1)+2*i] + full_q[layer_base(s-1)+2*i+1];
                    hi_q[layer_base(s)+i]   <= hi_q[layer_base(s-1)+2*i] + hi_q[layer_base(s-1)+2*i+1];
                    lo_q[layer_base(s)+i]   <= lo_q[layer_base(s-1)+2*i] + lo_q[layer_base(s-1)+2*i+1];
                end
            end
        end
    end

    // Lanes are merged only at the root, where the per-beat mode is known.
    always_comb begin
        beat_sum = halved_q[L] ? (FW'(hi_q[ROOT]) + FW'(lo_q[ROOT])) : full_q[ROOT];
        beat_ext = OUT_WIDTH'(beat_sum);
`ifdef TREE_ADDER_SATURATE_EN
        wide_sum = (OUT_WIDTH+1)'(acc_q) + (OUT_WIDTH+1)'(beat_ext);
        if (wide_sum[OUT_WIDTH] != wide_sum[OUT_WIDTH-1]) begin
            acc_sum = wide_sum[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else begin
            acc_sum = wide_sum[OUT_WIDTH-1:0];
        end
`else
        acc_sum = acc_q + beat_ext;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q       <= '0;
            halved_q    <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (!stall) begin
            vld_q    <= {vld_q[L-1:0], accept};
            halved_q <= {halved_q[L-1:0], in_halved_i};
            last_q   <= {last_q[L-1:0], beat_last};
            cnt_q    <= cnt_d;
            if (vld_q[L]) begin
                acc_q <= last_q[L] ? '0 : acc_sum;
            end
            if (vld_q[L] && last_q[L]) begin
                out_data_q  <= acc_sum;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_config_tree_adder.sv
// Randomised and directed bench for pipelined_config_tree_adder against a beat/group-level reference model.
module tb_pipelined_config_tree_adder;
    localparam int N  = 8;
    localparam int P  = 16;
    localparam int OW = 32;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [P-1:0]  in_data [N];
    logic                 in_halved;
    logic [15:0]          in_acc_len;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [OW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    always #5 clk = ~clk;

    pipelined_config_tree_adder #(.INPUTS_AMOUNT(N), .P(P), .OUT_WIDTH(OW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (in_data),
        .in_halved_i (in_halved),
        .in_acc_len_i(in_acc_len),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    int          n_total = 0;
    int          n_pass  = 0;
    int          model_cnt = 0;
    longint      model_acc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    // Inputs change just after posedge, so the negedge view is what the next edge consumes.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back(out_data);
    end

    function automatic longint beat_value(input bit halved);
        longint s = 0;
        logic [15:0] u;
        for (int i = 0; i < N; i++) begin
            u = in_data[i];
            if (halved) s += longint'($signed(u[15:8])) + longint'($signed(u[7:0]));
            else        s += longint'(in_data[i]);
        end
        return s;
    endfunction

    function automatic void model_accept(input bit halved, input logic [15:0] len);
        if (model_cnt == 0) begin
            model_cnt = (len == 16'd0) ? 1 : int'(len);
            model_acc = 0;
        end
        model_acc += beat_value(halved);
`ifdef TREE_ADDER_SATURATE_EN
        if (model_acc > MAXV) model_acc = MAXV;
        if (model_acc < MINV) model_acc = MINV;
`endif
        model_cnt--;
        if (model_cnt == 0) exp_q.push_back(model_acc[31:0]);
    endfunction

    task automatic set_all(input logic signed [15:0] v);
        for (int i = 0; i < N; i++) in_data[i] = v;
    endtask

    task automatic set_rand();
        for (int i = 0; i < N; i++) in_data[i] = 16'($urandom);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_beat(input bit halved, input logic [15:0] len);
        bit took = 1'b0;
        in_halved  = halved;
        in_acc_len = len;
        in_valid   = 1'b1;
        for (int k = 0; k < 200 && !took; k++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (took) model_accept(halved, len);
        else begin
            n_total++;
            $display("FAIL put_beat: in_ready still 0 after 200 cycles");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && got_q.size() < exp_q.size(); k++) @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_halved = 1'b0; in_acc_len = 16'd1;
        set_all(16'sd0);
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 32'd0) $display("FAIL reset_out_data got %0d want 0", out_data); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        rst = 1'b0;
        model_cnt = 0; exp_q.delete(); got_q.delete();
    endtask

    task automatic test_full_latency();
        int lat = -1;
        logic [31:0] seen = '0;
        set_all(16'sd1000);
        put_beat(1'b0, 16'd1);
        for (int n = 1; n <= 10 && lat < 0; n++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin lat = n; seen = out_data; end
        end
        n_total++; if (lat != 4) $display("FAIL full_latency got %0d want 4", lat); else n_pass++;
        n_total++; if (seen !== 32'd8000) $display("FAIL full_sum got %0d want 8000", $signed(seen)); else n_pass++;
        drain();
        n_total++; if (got_q.size() != exp_q.size()) $display("FAIL full_count got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL full_model[%0d] got %0d want %0d", i, $signed(got_q[i]), $signed(exp_q[i])); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_halved();
        set_all(16'sh7FFF);
        put_beat(1'b1, 16'd1);
        drain();
        n_total++; if (got_q.size() != 1) $display("FAIL halved_count got %0d want 1", got_q.size()); else n_pass++;
        if (got_q.size() >= 1 && exp_q.size() >= 1) begin
            n_total++; if (got_q[0] !== 32'd1008) $display("FAIL halved_sum got %0d want 1008", $signed(got_q[0])); else n_pass++;
            n_total++; if (got_q[0] !== exp_q[0]) $display("FAIL halved_model got %0d want %0d", $signed(got_q[0]), $signed(exp_q[0])); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_accumulate();
        set_all(-16'sd32768);
        for (int b = 0; b < 3; b++) put_beat(1'b0, 16'd4);
        idle(8);
        n_total++; if (got_q.size() != 0) $display("FAIL acc_intermediate got %0d results want 0", got_q.size()); else n_pass++;
        put_beat(1'b0, 16'd4);
        drain();
        n_total++; if (got_q.size() != 1) $display("FAIL acc_count got %0d want 1", got_q.size()); else n_pass++;
        if (got_q.size() >= 1 && exp_q.size() >= 1) begin
            n_total++; if (got_q[0] !== 32'hFFF0_0000) $display("FAIL acc_sum got %0d want -1048576", $signed(got_q[0])); else n_pass++;
            n_total++; if (got_q[0] !== exp_q[0]) $display("FAIL acc_model got %0d want %0d", $signed(got_q[0]), $signed(exp_q[0])); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        out_ready = 1'b1;
        fork
            begin
                for (int b = 0; b < 12; b++) begin set_rand(); put_beat(1'b0, 16'd1); end
            end
            begin
                repeat (7) @(posedge clk);
                #1;
                n_total++; if (out_valid !== 1'b1) $display("FAIL bp_streaming out_valid got %b want 1", out_valid); else n_pass++;
                out_ready = 1'b0;
                held = out_data;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cycle %0d got %b want 0", c, in_ready); else n_pass++;
                    n_total++; if (out_data !== held) $display("FAIL bp_hold cycle %0d got %0d want %0d", c, out_data, $signed(held)); else n_pass++;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        n_total++; if (got_q.size() != exp_q.size()) $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL bp_order[%0d] got %0d want %0d", i, $signed(got_q[i]), $signed(exp_q[i])); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int b = 0; b < 80; b++) begin
                    set_rand();
                    if ($urandom_range(3) == 0) idle(int'($urandom_range(2)) + 1);
                    put_beat(1'($urandom_range(1)), 16'($urandom_range(5)));
                end
                while (model_cnt != 0) begin set_rand(); put_beat(1'($urandom_range(1)), 16'd1); end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        n_total++; if (got_q.size() != exp_q.size()) $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_result[%0d] got %0d want %0d", i, $signed(got_q[i]), $signed(exp_q[i])); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid_group();
        set_all(16'sd5);
        put_beat(1'b0, 16'd4);
        put_beat(1'b0, 16'd4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_cnt = 0; model_acc = 0;
        set_all(16'sd1);
        for (int b = 0; b < 4; b++) put_beat(1'b0, 16'd4);
        drain();
        n_total++; if (got_q.size() != 1) $display("FAIL rstmid_count got %0d want 1", got_q.size()); else n_pass++;
        if (got_q.size() >= 1 && exp_q.size() >= 1) begin
            n_total++; if (got_q[0] !== 32'd32) $display("FAIL rstmid_sum got %0d want 32", $signed(got_q[0])); else n_pass++;
            n_total++; if (got_q[0] !== exp_q[0]) $display("FAIL rstmid_model got %0d want %0d", $signed(got_q[0]), $signed(exp_q[0])); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_overflow();
        logic [31:0] want;
`ifdef TREE_ADDER_SATURATE_EN
        want = 32'h8000_0000;
`else
        want = 32'd262144;
`endif
        set_all(-16'sd32768);
        for (int b = 0; b < 65535; b++) put_beat(1'b0, 16'hFFFF);
        drain();
        n_total++; if (got_q.size() != 1) $display("FAIL ovf_count got %0d want 1", got_q.size()); else n_pass++;
        if (got_q.size() >= 1 && exp_q.size() >= 1) begin
            n_total++; if (got_q[0] !== want) $display("FAIL ovf_sum got %h want %h", got_q[0], want); else n_pass++;
            n_total++; if (got_q[0] !== exp_q[0]) $display("FAIL ovf_model got %h want %h", got_q[0], exp_q[0]); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset();
        test_full_latency();
        test_halved();
        test_accumulate();
        test_backpressure();
        test_random();
        test_reset_mid_group();
        test_overflow();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipelined_config_tree_adder.md
# pipelined_config_tree_adder

Pipelined, valid/ready-handshaked reduction tree that sums INPUTS_AMOUNT signed P-bit operands per beat, either at full precision or as two packed P/2-bit lanes per operand. Tree sums are accumulated over a runtime-programmable number of beats before one 32-bit result is emitted. It sits between the multiplier array and the output writeback of the matrix engine. It replaces the purely combinational tree where timing closure needs one register per layer, and where dot products span several input beats.

## Interface
- INPUTS_AMOUNT, default 8: operands per beat; power of 2, ≥2; elaboration `$fatal` otherwise.
- P, default 16: operand width; even, ≥4.
- OUT_WIDTH, default 32: result width; must be ≥ P+log2(INPUTS_AMOUNT)+1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; **synchronous, active-high**, single clock domain
- in_data  in  signed [P-1:0] [INPUTS_AMOUNT]  operand array
- in_halved  in  1  per-beat mode: 1 = two signed P/2 lanes per operand
- in_acc_len  in  16  beats per group; sampled on the first beat of a group; 0 treated as 1
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- out_data  out  signed [OUT_WIDTH-1:0]  group sum
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts

## Operation
- L = log2(INPUTS_AMOUNT) tree layers.
  - Layer k output width is P+k+1, with sign extension on every add.
  - Each layer is registered.
  - in_halved travels with the data through a valid/mode shift register.
- Full mode:
  - Each layer adds adjacent pairs at full width.
  - Beat sum = Σ in_data[i].
- Halved mode:
  - Operand i splits into hi = in_data[i][P-1:P/2] and lo = in_data[i][P/2-1:0], both signed.
  - Lanes are reduced independently, with layer k lane width P/2+k+1.
  - Beat sum = Σ(hi+lo), formed after the last layer.
- The beat sum is sign-extended to OUT_WIDTH and added into the accumulator.
- Beat counter:
  - Loads group length at the first beat.
  - On the last beat the accumulator plus the beat sum is written to out_data and out_valid is set.
  - The accumulator then clears for the next group.
- Mode may differ between beats of one group; each beat uses its own mode.
- Accumulator overflow wraps modulo 2^OUT_WIDTH, unless the configuration macro below is defined.

## Timing
- Reset values: out_data=0, out_valid=0, accumulator=0, beat counter=0, all pipeline valids=0, in_ready=1.
- Latency: a last beat accepted at edge t gives out_valid=1 from edge t+L+1.
- Throughput is one beat per cycle when not stalled.
- Stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, every pipeline register, counter and the accumulator hold.
  - out_data is stable.
- out_valid clears on the edge where out_valid && out_ready, unless a new result is written on the same edge.
- Back-to-back groups with acc_len=1 produce one result per cycle.
- A beat with in_valid=0 injects a bubble; the counter does not advance.
- rst mid-group or mid-stall:
  - All in-flight beats and partial sums are discarded.
  - The next accepted beat starts a new group.

## Configuration
- TREE_ADDER_SATURATE_EN
  - Defined: accumulator add saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Undefined: two's-complement wrap.
- The tree itself never overflows, because widths grow per layer.

## Test plan
All cases use INPUTS_AMOUNT=8, P=16, OUT_WIDTH=32; latency = 4 cycles.
- Full mode: acc_len=1, all operands 1000 → out_data=8000, out_valid exactly 4 cycles after acceptance.
- Halved mode: acc_len=1, all operands 16'h7FFF (lanes 127, −1) → out_data=1008.
- Accumulation: acc_len=4, four beats of all −32768 → single result −1048576 after the 4th beat; no intermediate out_valid.
- Backpressure: results streaming with acc_len=1, then out_ready=0 for 5 cycles.
  - in_ready=0 throughout; out_data held.
  - After release, all results appear in order; none lost or duplicated.
- Overflow: acc_len=65535, every beat all −32768.
  - Without the macro: out_data=262144.
  - With TREE_ADDER_SATURATE_EN: out_data=32'h80000000.
- Reset mid-group: acc_len=4, 2 beats accepted, rst high 1 cycle, then 4 beats of all 1 → out_data=32, no output from the aborted group.
